mem_stage: RTL and testbench

- Memory stage of the 5-stage MIPS pipeline, directly downstream of ex_stage.
- Latches ex_stage results into the EX/MEM register and performs word loads/stores on an internal data RAM.
- Produces the MEM/WB register contents for write-back, plus forwarding taps for the EX stage.
- Supports a configurable multi-cycle memory latency; it stalls the upstream pipeline while an access is in flight.

---
 rtl/mips_pipe_pkg.sv | 30 +++
 rtl/data_mem.sv | 24 ++
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: memory-stage FSM encoding, EX/MEM payload and default sizing.
package mips_pipe_pkg;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_MEM_LATENCY = 1;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned REG_W           = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rt;
    logic [REG_W-1:0]  waddr;
    logic              wreg;
    logic              wmem;
    logic              m2r;
  } ex_mem_t;

  // Wait counter must be able to hold the value MEM_LATENCY itself
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 2) ? 1 : int'($clog2(lat + 1));
  endfunction

endpackage

// File: rtl/data_mem.sv
// Single-port word RAM: asynchronous read, synchronous write, no reset.
module data_mem #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, data RAM access with configurable wait states, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN adds an align_err output and drops misaligned loads/stores.
module mem_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ALUoutputData_ex,
  input  logic [DATA_W-1:0] rtData_ex,
  input  logic [REG_W-1:0]  RegFileWtAddr_ex,
  input  logic              wreg_ex,
  input  logic              wmem_ex,
  input  logic              Mem2Reg_ex,
  output logic              mem_stall,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              align_err,
`endif
  output logic [DATA_W-1:0] WtData_wb,
  output logic [REG_W-1:0]  WtAddr_wb,
  output logic              wreg_wb,
  output logic [DATA_W-1:0] fwd_data_mem,
  output logic [REG_W-1:0]  fwd_addr_mem,
  output logic              fwd_wreg_mem
);

  localparam int unsigned CNT_W = cnt_width(MEM_LATENCY);

  ex_mem_t           exm_q, exm_d;
  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall_c;
  logic              mem_op;
  logic              is_load;
  logic              misalign;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_addr_q, wb_addr_d;
  logic              wb_wreg_q, wb_wreg_d;

  assign mem_op   = exm_q.wmem | exm_q.m2r;
  assign is_load  = exm_q.m2r & ~exm_q.wmem;
  assign ram_addr = exm_q.alu[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (exm_q.alu[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Store commits on the edge its access completes, before the next entry is latched
  assign ram_we = ~stall_c & exm_q.wmem & ~misalign;

  data_mem #(
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (exm_q.rt),
    .rdata_o (ram_rdata)
  );

  // Wait-state FSM: stall is asserted combinationally for MEM_LATENCY cycles per mem-op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (mem_op && !misalign && (MEM_LATENCY != 0)) begin
          stall_c = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (cnt_q < CNT_W'(MEM_LATENCY)) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    exm_d = exm_q;
    if (!stall_c) begin
      exm_d.alu   = ALUoutputData_ex;
      exm_d.rt    = rtData_ex;
      exm_d.waddr = RegFileWtAddr_ex;
      exm_d.wreg  = wreg_ex;
      exm_d.wmem  = wmem_ex;
      exm_d.m2r   = Mem2Reg_ex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_q <= '0;
    end else begin
      exm_q <= exm_d;
    end
  end

  // MEM/WB: a bubble (wreg=0) enters while stalled; data and address hold
  always_comb begin
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wb_wreg_d = 1'b0;
    if (!stall_c) begin
      wb_data_d = is_load ? ram_rdata : exm_q.alu;
      wb_addr_d = exm_q.waddr;
      wb_wreg_d = exm_q.wreg & ~exm_q.wmem & ~misalign & (exm_q.waddr != REG_ZERO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_wreg_q <= 1'b0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_wreg_q <= wb_wreg_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic align_q, align_d;

  assign align_d = ~stall_c & misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_q <= 1'b0;
    end else begin
      align_q <= align_d;
    end
  end

  assign align_err = align_q;
`endif

  assign mem_stall    = stall_c;
  assign WtData_wb    = wb_data_q;
  assign WtAddr_wb    = wb_addr_q;
  assign wreg_wb      = wb_wreg_q;
  assign fwd_data_mem = exm_q.alu;
  assign fwd_addr_mem = exm_q.waddr;
  assign fwd_wreg_mem = exm_q.wreg & (exm_q.waddr != REG_ZERO);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a zero-latency and a two-cycle-latency instance share one input bus.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu, rt;
  logic [4:0]  wa;
  logic        wreg, wmem, m2r;

  logic        s0, w0, fw0, s2, w2, fw2;
  logic [31:0] d0, fd0, d2, fd2;
  logic [4:0]  a0, fa0, a2, fa2;
`ifdef MEM_ALIGN_CHECK_EN
  logic        ae0, ae2;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage #(.MEM_LATENCY(0), .ADDR_W(8)) u_l0 (
    .clk(clk), .rst_n(rst_n),
    .ALUoutputData_ex(alu), .rtData_ex(rt), .RegFileWtAddr_ex(wa),
    .wreg_ex(wreg), .wmem_ex(wmem), .Mem2Reg_ex(m2r),
    .mem_stall(s0),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err(ae0),
`endif
    .WtData_wb(d0), .WtAddr_wb(a0), .wreg_wb(w0),
    .fwd_data_mem(fd0), .fwd_addr_mem(fa0), .fwd_wreg_mem(fw0)
  );

  mem_stage #(.MEM_LATENCY(2), .ADDR_W(8)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .ALUoutputData_ex(alu), .rtData_ex(rt), .RegFileWtAddr_ex(wa),
    .wreg_ex(wreg), .wmem_ex(wmem), .Mem2Reg_ex(m2r),
    .mem_stall(s2),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err(ae2),
`endif
    .WtData_wb(d2), .WtAddr_wb(a2), .wreg_wb(w2),
    .fwd_data_mem(fd2), .fwd_addr_mem(fa2), .fwd_wreg_mem(fw2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wa;
    logic        wreg;
    logic        wmem;
    logic        m2r;
    logic        ewreg;
    logic [31:0] edata;
    logic        edchk;
    logic        efwd;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] r, input logic [4:0] d,
                              input logic w, input logic wm, input logic m,
                              input logic ew, input logic [31:0] ed, input logic edc, input logic ef);
    vec_t v;
    v.alu = a; v.rt = r; v.wa = d; v.wreg = w; v.wmem = wm; v.m2r = m;
    v.ewreg = ew; v.edata = ed; v.edchk = edc; v.efwd = ef;
    return v;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] r, input logic [4:0] d,
                       input logic w, input logic wm, input logic m);
    alu = a; rt = r; wa = d; wreg = w; wmem = wm; m2r = m;
  endtask

  task automatic idle_in();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Issue one op to the latency-2 instance and run it to completion; n = stall cycles seen
  task automatic l2_op(input logic [31:0] a, input logic [31:0] r, input logic [4:0] d,
                       input logic w, input logic wm, input logic m, output int n);
    drive(a, r, d, w, wm, m);
    cyc();
    idle_in();
    n = 0;
    while (s2 && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) begin
      errors++;
      checks++;
      $display("FAIL l2_op_timeout actual=%0d required<20", n);
    end
    cyc();
  endtask

  initial begin
    vec_t e;
    int   n;

    vecs[0] = mk(32'h0000_1234, 32'h0,         5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 1'b1, 1'b1);
    vecs[1] = mk(32'h0000_0040, 32'hCAFE_F00D, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
    vecs[2] = mk(32'h0000_0040, 32'h0,         5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1);
    vecs[3] = mk(32'h0000_FFFF, 32'h0,         5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0);
    vecs[4] = mk(32'h0000_0044, 32'h1111_1111, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
    vecs[5] = mk(32'h0000_0080, 32'h2222_2222, 5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1);
    vecs[6] = mk(32'h0000_0044, 32'h0,         5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 1'b1);
    vecs[7] = mk(32'hFFFF_FC80, 32'h0,         5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
    vecs[8] = mk(32'h0000_0041, 32'h0,         5'd6,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1);
`else
    vecs[8] = mk(32'h0000_0041, 32'h0,         5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1);
`endif
    vecs[9] = mk(32'h0000_ABCD, 32'h0,         5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_ABCD, 1'b1, 1'b0);

    // Reset held during traffic
    rst_n = 1'b0;
    drive(32'h0000_0040, 32'h5555_5555, 5'd7, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chkb("rst_hold_wreg_wb", w0, 1'b0);
      chkb("rst_hold_stall_l2", s2, 1'b0);
    end
    idle_in();
    rst_n = 1'b1;
    #1;
    chkb("rst_rel_wreg_wb", w0, 1'b0);
    chk("rst_rel_wtdata", d0, 32'h0);
    chkb("rst_rel_stall_l0", s0, 1'b0);
    chkb("rst_rel_stall_l2", s2, 1'b0);
    chkb("rst_rel_fwd_wreg", fw0, 1'b0);
    @(negedge clk);

    // Table-driven pass on the zero-latency instance
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].alu, vecs[i].rt, vecs[i].wa, vecs[i].wreg, vecs[i].wmem, vecs[i].m2r);
      cyc();
      chkb($sformatf("v%0d_stall", i), s0, 1'b0);
      chk($sformatf("v%0d_fwd_data", i), fd0, vecs[i].alu);
      chk($sformatf("v%0d_fwd_addr", i), 32'(fa0), 32'(vecs[i].wa));
      chkb($sformatf("v%0d_fwd_wreg", i), fw0, vecs[i].efwd);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chkb($sformatf("wb_wreg(%h)", e.alu), w0, e.ewreg);
        chk($sformatf("wb_addr(%h)", e.alu), 32'(a0), 32'(e.wa));
        if (e.edchk) chk($sformatf("wb_data(%h)", e.alu), d0, e.edata);
      end
      sb.push_back(vecs[i]);
    end
    idle_in();
    cyc();
    chkb("tail_stall", s0, 1'b0);
    e = sb.pop_front();
    chkb("tail_wb_wreg", w0, e.ewreg);
    chk("tail_wb_data", d0, e.edata);
    chk("tail_wb_addr", 32'(a0), 32'(e.wa));

    // Latency-2: store then non-mem-op then load
    do_reset();
    drive(32'h0000_0040, 32'h5A5A_5A5A, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    chkb("lat_st_stall_c1", s2, 1'b1);
    drive(32'h0000_0777, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc();
    chkb("lat_st_stall_c2", s2, 1'b1);
    chkb("lat_st_bubble", w2, 1'b0);
    chk("lat_st_exmem_hold", fd2, 32'h0000_0040);
    cyc();
    chkb("lat_st_stall_c3", s2, 1'b0);
    cyc();
    chkb("lat_nonmem_nostall", s2, 1'b0);
    chkb("lat_store_no_wreg", w2, 1'b0);
    chk("lat_nonmem_latched", fd2, 32'h0000_0777);
    drive(32'h0000_0040, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1);
    cyc();
    chkb("lat_nonmem_wreg", w2, 1'b1);
    chk("lat_nonmem_data", d2, 32'h0000_0777);
    chk("lat_nonmem_addr", 32'(a2), 32'd7);
    idle_in();
    n = 0;
    while (s2 && n < 10) begin
      if (n > 0) chkb("lat_ld_bubble", w2, 1'b0);
      chk("lat_ld_exmem_hold", fd2, 32'h0000_0040);
      cyc();
      n++;
    end
    chk("lat_ld_stall_cycles", 32'(n), 32'd2);
    cyc();
    chk("lat_ld_data", d2, 32'h5A5A_5A5A);
    chkb("lat_ld_wreg", w2, 1'b1);
    chk("lat_ld_addr", 32'(a2), 32'd8);

    // Reset in the middle of a store's wait states aborts the store
    do_reset();
    l2_op(32'h0000_0010, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, n);
    drive(32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    idle_in();
    chkb("abort_stall_before", s2, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chkb("abort_stall_in_rst", s2, 1'b0);
    chk("abort_wtdata_in_rst", d2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    l2_op(32'h0000_0010, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, n);
    chk("abort_load_data", d2, 32'h0);
    chkb("abort_load_wreg", w2, 1'b1);
    chk("abort_load_stalls", 32'(n), 32'd2);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned store: no stall, one-cycle align_err, RAM untouched
    drive(32'h0000_0042, 32'h9999_9999, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    chkb("align_st_nostall", s2, 1'b0);
    chkb("align_err_pre", ae2, 1'b0);
    drive(32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
    cyc();
    chkb("align_err_set", ae2, 1'b1);
    chkb("align_err_wreg", w2, 1'b0);
    idle_in();
    n = 0;
    while (s2 && n < 10) begin
      cyc();
      n++;
      chkb("align_err_clear", ae2, 1'b0);
    end
    cyc();
    chk("align_ld_prior", d2, 32'h5A5A_5A5A);
    chkb("align_ld_wreg", w2, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
